risc_lsu: RTL and testbench
===========================

# risc_lsu

Load/store unit for the RISC2 core: the initiator on the single-port 64x32 data memory interface (asynchronous read, synchronous write on MW). It accepts load/store requests from the execute stage over a valid/ready handshake, drives the memory port, and returns load data (and store acknowledgements) over a valid/ready response channel. Optionally supports burst loads of consecutive words with address wrap-around.

## Interface
- ADDR_W, 6: memory word-address width (depth 2^ADDR_W = 64).
- DATA_W, 32: data word width.
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  start word address.
- req_wdata  in  DATA_W  store data.
- req_len  in  ADDR_W  burst load length minus one (0 = 1 word, 63 = 64 words); ignored for stores.
- resp_valid  out  1  response word valid.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_data  out  DATA_W  load data; for stores, the data written.
- resp_last  out  1  final word of the request.
- mem_addr  out  ADDR_W  to memory addr.
- mem_we  out  1  to memory MW.
- mem_wdata  out  DATA_W  to memory data_in.
- mem_rdata  in  DATA_W  from memory data_out (combinational read).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready = 1. On accept, latch we, addr into cur_addr, wdata, remaining = req_len (0 for stores); go ACCESS.
- ACCESS (one cycle): mem_addr = cur_addr. Load: capture mem_rdata into resp_data. Store: mem_we = 1, mem_wdata = latched wdata, resp_data = wdata. Go RESP.
- RESP: resp_valid = 1, resp_last = (remaining == 0). Hold resp_data, cur_addr, remaining until resp_ready. On handshake: remaining == 0 -> IDLE; else cur_addr = cur_addr + 1 modulo 2^ADDR_W (63 wraps to 0), remaining - 1, -> ACCESS.
- mem_addr always driven from cur_addr; mem_wdata from latched wdata; mem_we is 0 outside ACCESS-store.
- req_ready is 0 in ACCESS and RESP; no request queuing.
- mem_we = (state == ACCESS) && store && !reset: reset asserted during a store's ACCESS cycle suppresses the write.
- req_ready and resp_valid are forced to 0 while reset is high.
- Reset mid-operation: state -> IDLE at the edge; burst abandoned, no further responses.

## Timing
- Reset values: state IDLE, cur_addr 0, remaining 0, resp_data 0, wdata 0; outputs req_ready 0 (while reset), resp_valid 0, resp_last 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Accept at edge N -> ACCESS in cycle N+1 -> resp_valid from cycle N+2.
- Burst throughput: one word per two cycles with resp_ready held high; each resp_ready-low cycle adds one stall.
- Back-to-back: the cycle after the final response handshake is IDLE, so req_ready is high then; minimum request-to-request spacing 3 cycles.
- Store commits at the edge ending ACCESS; a load issued next reads the new value.

## Configuration
- RISC_LSU_BURST_EN defined: req_len honoured as above.
- Undefined: req_len ignored, remaining always 0; every load returns exactly one word with resp_last = 1; the increment/wrap logic is removed.

## Structure
- Shared package risc_lsu_pkg: FSM state enum (IDLE, ACCESS, RESP), ADDR_W/DATA_W defaults, MEM_DEPTH = 64.
- One sub-module: risc_lsu_burst_ctr, holding cur_addr/remaining with load, step (increment with wrap, decrement), and last flag; instantiated under RISC_LSU_BURST_EN, replaced by plain address register otherwise.

## Test plan
Memory initialised to memory[i] = i.
- Load addr 5, len 0 -> resp_data 5, resp_last 1, resp_valid exactly 2 cycles after accept; req_ready high again the cycle after the response handshake.
- Store 0xDEADBEEF to 12, then load 12 -> mem_we high for exactly one cycle with mem_addr 12; load returns 0xDEADBEEF.
- Burst load addr 62, len 3 -> responses 62, 63, 0, 1; resp_last only on the 4th.
- Same burst with resp_ready low for 3 cycles on the 2nd word -> resp_data holds 63, mem_addr holds 63, no word lost or duplicated.
- Reset asserted in RESP after 2nd burst word -> resp_valid 0 from the next cycle, state IDLE; reset during a store's ACCESS cycle -> mem_we 0, memory unchanged.
- RISC_LSU_BURST_EN undefined, load addr 10, len 3 -> single response 10 with resp_last 1.

Source files
------------

// File: rtl/risc_lsu_pkg.sv
// risc_lsu shared types and defaults.
// FSM state encoding and memory geometry for the load/store unit.
package risc_lsu_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;
    localparam int MEM_DEPTH  = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

endpackage

// File: rtl/risc_lsu_burst_ctr.sv
// risc_lsu burst address/length counter.
// Walks consecutive word addresses (wrapping) and flags the final word.
module risc_lsu_burst_ctr #(
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [ADDR_W-1:0] i_len,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_rem;

    // load a new burst, or advance to the next word (address wraps naturally)
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_addr <= '0;
            r_rem  <= '0;
        end else if (i_load) begin
            r_addr <= i_addr;
            r_rem  <= i_len;
        end else if (i_step) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_rem == '0);

endmodule

// File: rtl/risc_lsu.sv
// risc_lsu: load/store unit driving the 64x32 data memory port.
// Define RISC_LSU_BURST_EN to honour req_len as a burst-load length.
module risc_lsu
    import risc_lsu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [ADDR_W-1:0] req_len,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        r_state;
    lsu_state_e        w_next;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;
    logic              w_accept;
    logic              w_hs;

    assign w_accept = (r_state == IDLE) && req_valid && !reset;
    assign w_hs     = (r_state == RESP) && resp_ready && !reset;

`ifdef RISC_LSU_BURST_EN
    logic [ADDR_W-1:0] w_len;

    assign w_len = req_we ? '0 : req_len;

    risc_lsu_burst_ctr #(
        .ADDR_W (ADDR_W)
    ) u_ctr (
        .CLK    (CLK),
        .reset  (reset),
        .i_load (w_accept),
        .i_addr (req_addr),
        .i_len  (w_len),
        .i_step (w_hs && !w_last),
        .o_addr (w_addr),
        .o_last (w_last)
    );
`else
    logic [ADDR_W-1:0] r_addr;
    logic              w_unused_len;

    assign w_unused_len = ^req_len;

    // single-word mode: just hold the request address
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= req_addr;
        end
    end

    assign w_addr = r_addr;
    assign w_last = 1'b1;
`endif

    // state register
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next state and handshake/memory strobes
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_last  = 1'b0;
        mem_we     = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = !reset;
                if (w_accept) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_we = r_we && !reset;
                w_next = RESP;
            end
            RESP: begin
                resp_valid = !reset;
                resp_last  = w_last && !reset;
                if (w_hs) begin
                    w_next = w_last ? IDLE : ACCESS;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // latch request fields; capture the response word during ACCESS
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_wdata <= req_wdata;
            end
            if (r_state == ACCESS) begin
                r_rdata <= r_we ? r_wdata : mem_rdata;
            end
        end
    end

    assign mem_addr  = w_addr;
    assign mem_wdata = r_wdata;
    assign resp_data = r_rdata;

endmodule

// File: tb/tb_risc_lsu.sv
// Testbench for risc_lsu with a 64x32 memory and a transaction-level model.
// Honours RISC_LSU_BURST_EN the same way the design does.
module tb_risc_lsu;

`ifdef RISC_LSU_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [5:0]  req_len = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_last;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    risc_lsu dut (
        .CLK        (CLK),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_len    (req_len),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // data memory: asynchronous read, synchronous write
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'(i);
            ref_mem[i] = 32'(i);
        end
    end

    assign mem_rdata = mem[mem_addr];

    always @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Outstanding request = queue of expected words; m_wait counts the
    // memory-access cycle that precedes every word.
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    bit          m_store = 1'b0;
    logic [31:0] q_data[$];
    logic        q_last[$];
    logic [5:0]  q_addr[$];

    always @(posedge CLK) begin
        if (reset) begin
            m_busy = 1'b0;
            m_wait = 0;
            q_data.delete();
            q_last.delete();
            q_addr.delete();
        end else if (!m_busy) begin
            if (req_valid) begin
                int n;
                m_busy  = 1'b1;
                m_wait  = 1;
                m_store = req_we;
                n = (req_we || !BURST) ? 1 : int'(req_len) + 1;
                for (int i = 0; i < n; i++) begin
                    logic [5:0] a;
                    a = 6'((int'(req_addr) + i) % 64);
                    q_addr.push_back(a);
                    q_data.push_back(req_we ? req_wdata : ref_mem[a]);
                    q_last.push_back(i == n - 1);
                end
            end
        end else if (m_wait == 1) begin
            if (m_store) ref_mem[q_addr[0]] = q_data[0];
            m_wait = 0;
        end else if (resp_ready) begin
            void'(q_data.pop_front());
            void'(q_last.pop_front());
            void'(q_addr.pop_front());
            if (q_data.size() == 0) m_busy = 1'b0;
            else m_wait = 1;
        end
    end

    // per-cycle comparison of DUT outputs against the model
    always @(negedge CLK) begin
        logic e_rdy, e_val, e_we, e_acc;
        e_rdy = !reset && !m_busy;
        e_val = !reset && m_busy && (m_wait == 0);
        e_acc = !reset && m_busy && (m_wait == 1);
        e_we  = e_acc && m_store;
        chk("req_ready", 32'(req_ready), 32'(e_rdy));
        chk("resp_valid", 32'(resp_valid), 32'(e_val));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_val) begin
            chk("resp_data", resp_data, q_data[0]);
            chk("resp_last", 32'(resp_last), 32'(q_last[0]));
            chk("resp_addr", 32'(mem_addr), 32'(q_addr[0]));
        end
        if (e_acc) chk("acc_addr", 32'(mem_addr), 32'(q_addr[0]));
        if (e_we) chk("mem_wdata", mem_wdata, q_data[0]);
    end

    // ---------------- stimulus helpers ----------------
    int          we_cnt = 0;
    logic [5:0]  we_addr = '0;

    always @(negedge CLK) begin
        if (mem_we === 1'b1) begin
            we_cnt++;
            we_addr = mem_addr;
        end
    end

    logic [31:0] got_data[$];
    logic        got_last[$];
    logic [31:0] st_data[$];
    logic [5:0]  st_addr[$];
    int          acc_cyc;
    int          first_cyc;

    task automatic xact(input bit we, input logic [5:0] a,
                        input logic [31:0] wd, input logic [5:0] len,
                        input int stall_word, input int stall_n,
                        input bit rnd);
        int t, widx, scnt;
        bit done;
        got_data.delete();
        got_last.delete();
        st_data.delete();
        st_addr.delete();
        acc_cyc = -1;
        first_cyc = -1;
        req_we = we;
        req_addr = a;
        req_wdata = wd;
        req_len = len;
        req_valid = 1'b1;
        t = 0;
        @(negedge CLK);
        while (!req_ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("req_accept", 32'(req_ready), 32'd1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        widx = 0;
        scnt = 0;
        done = 1'b0;
        t = 0;
        while (!done && t < 3000) begin
            if (rnd) resp_ready = ($urandom % 4) != 0;
            else resp_ready = !(widx == stall_word && scnt < stall_n);
            @(negedge CLK);
            if (resp_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (resp_ready) begin
                    got_data.push_back(resp_data);
                    got_last.push_back(resp_last);
                    widx++;
                    if (resp_last) done = 1'b1;
                end else if (widx == stall_word) begin
                    scnt++;
                    st_data.push_back(resp_data);
                    st_addr.push_back(mem_addr);
                end
            end
            @(posedge CLK);
            #1;
            t++;
        end
        resp_ready = 1'b0;
        chk("resp_complete", 32'(done), 32'd1);
    endtask

    task automatic chk_words(input string nm, input logic [31:0] d[$],
                             input logic l[$]);
        chk({nm, "_count"}, 32'(got_data.size()), 32'(d.size()));
        for (int i = 0; i < d.size() && i < got_data.size(); i++) begin
            chk($sformatf("%s_data%0d", nm, i), got_data[i], d[i]);
            chk($sformatf("%s_last%0d", nm, i), 32'(got_last[i]), 32'(l[i]));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_last", 32'(resp_last), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        @(posedge CLK);
        #1;

        // single load
        xact(1'b0, 6'd5, 32'd0, 6'd0, -1, 0, 1'b0);
        chk_words("ld5", '{32'd5}, '{1'b1});
        chk("ld5_latency", 32'(first_cyc - acc_cyc), 32'd2);
        @(negedge CLK);
        chk("ld5_ready_after", 32'(req_ready), 32'd1);
        @(posedge CLK);
        #1;

        // store then load back
        we_cnt = 0;
        xact(1'b1, 6'd12, 32'hDEADBEEF, 6'd0, -1, 0, 1'b0);
        chk_words("st12", '{32'hDEADBEEF}, '{1'b1});
        chk("st12_we_cycles", 32'(we_cnt), 32'd1);
        chk("st12_we_addr", 32'(we_addr), 32'd12);
        xact(1'b0, 6'd12, 32'd0, 6'd0, -1, 0, 1'b0);
        chk_words("ld12", '{32'hDEADBEEF}, '{1'b1});

`ifdef RISC_LSU_BURST_EN
        // wrapping burst, then the same burst with a stall on word 2
        xact(1'b0, 6'd62, 32'd0, 6'd3, -1, 0, 1'b0);
        chk_words("burst", '{32'd62, 32'd63, 32'd0, 32'd1},
                  '{1'b0, 1'b0, 1'b0, 1'b1});
        xact(1'b0, 6'd62, 32'd0, 6'd3, 1, 3, 1'b0);
        chk_words("burst_stall", '{32'd62, 32'd63, 32'd0, 32'd1},
                  '{1'b0, 1'b0, 1'b0, 1'b1});
        chk("stall_cycles", 32'(st_data.size()), 32'd3);
        for (int i = 0; i < st_data.size(); i++) begin
            chk("stall_data", st_data[i], 32'd63);
            chk("stall_addr", 32'(st_addr[i]), 32'd63);
        end
`else
        // length is ignored without burst support
        xact(1'b0, 6'd10, 32'd0, 6'd3, -1, 0, 1'b0);
        chk_words("noburst", '{32'd10}, '{1'b1});
`endif

        // reset while a response is presented
        req_we = 1'b0;
        req_addr = 6'd62;
        req_len = 6'd3;
        req_valid = 1'b1;
        t = 0;
        @(negedge CLK);
        while (!req_ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        @(posedge CLK);
        #1 req_valid = 1'b0;
`ifdef RISC_LSU_BURST_EN
        resp_ready = 1'b1;
        t = 0;
        @(negedge CLK);
        while (!resp_valid && t < 20) begin
            @(negedge CLK);
            t++;
        end
        @(posedge CLK);
        #1 resp_ready = 1'b0;
`endif
        t = 0;
        @(negedge CLK);
        while (!resp_valid && t < 20) begin
            @(negedge CLK);
            t++;
        end
        chk("rstmid_valid_before", 32'(resp_valid), 32'd1);
        chk("rstmid_data_before", resp_data, BURST ? 32'd63 : 32'd62);
        @(posedge CLK);
        #1 reset = 1'b1;
        @(negedge CLK);
        chk("rstmid_valid_during", 32'(resp_valid), 32'd0);
        @(posedge CLK);
        #1 reset = 1'b0;
        resp_ready = 1'b1;
        @(negedge CLK);
        chk("rstmid_idle_ready", 32'(req_ready), 32'd1);
        chk("rstmid_addr", 32'(mem_addr), 32'd0);
        repeat (4) begin
            @(negedge CLK);
            chk("rstmid_no_resp", 32'(resp_valid), 32'd0);
        end
        @(posedge CLK);
        #1 resp_ready = 1'b0;

        // reset during a store's access cycle suppresses the write
        req_we = 1'b1;
        req_addr = 6'd20;
        req_wdata = 32'h12345678;
        req_valid = 1'b1;
        t = 0;
        @(negedge CLK);
        while (!req_ready && t < 50) begin
            @(negedge CLK);
            t++;
        end
        @(posedge CLK);
        #1 req_valid = 1'b0;
        reset = 1'b1;
        @(negedge CLK);
        chk("rstst_mem_we", 32'(mem_we), 32'd0);
        @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        chk("rstst_mem20", mem[20], 32'd20);
        chk("rstst_ready", 32'(req_ready), 32'd1);
        @(posedge CLK);
        #1;

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            bit          we;
            logic [5:0]  a, len;
            logic [31:0] wd;
            int          exp_n;
            we = ($urandom % 3) == 0;
            a = 6'($urandom);
            wd = $urandom;
            len = (($urandom % 8) == 0) ? 6'd63 : 6'($urandom % 8);
            xact(we, a, wd, len, -1, 0, 1'b1);
            exp_n = (we || !BURST) ? 1 : int'(len) + 1;
            chk("rnd_nwords", 32'(got_data.size()), 32'(exp_n));
            repeat ($urandom % 3) @(posedge CLK);
            #1;
        end

        repeat (2) @(posedge CLK);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
